ret_stack: RTL and testbench



---
 rtl/puc_pkg.sv | 17 +
 rtl/ret_stack_mem.sv | 35 +++
 rtl/ret_stack.sv | 122 ++++++++++++
 tb/tb_ret_stack.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/puc_pkg.sv
// rtl/puc_pkg.sv - shared opcode and address definitions for the program counter and return stack
//
// Purpose : opcode constants decoded by both the program counter and ret_stack,
//           plus the instruction address type at its default width.
// Ports   : none (package).
package puc_pkg;

  localparam logic [1:0] OP_RESTART = 2'd0;
  localparam logic [1:0] OP_JMP     = 2'd1;
  localparam logic [1:0] OP_RET     = 2'd2;
  localparam logic [1:0] OP_INC     = 2'd3;

  localparam int unsigned INSTR_ADDR_SIZE_DEF = 5;

  typedef logic [INSTR_ADDR_SIZE_DEF-1:0] instr_addr_t;

endpackage

// File: rtl/ret_stack_mem.sv
// rtl/ret_stack_mem.sv - DEPTH x WIDTH register array, one write port, one async read port
//
// Purpose : entry storage for ret_stack; every entry clears to 0 on reset.
// Ports   : clk_i, rst_ni        clock, asynchronous active-low reset
//           we_i, waddr_i, wdata_i  synchronous write port
//           raddr_i, rdata_o     combinational read port
module ret_stack_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 5,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address stack decoding the program counter opcode
//
// Purpose : pushes INSTR_ADDR+1 on a call (OP_JMP with CALL), pops on OP_RET,
//           empties on OP_RESTART; RET_ADDR is a combinational read of the top.
// Ports   : CLK, RST_N          clock, asynchronous active-low reset
//           OP_CODE, CALL, INSTR_ADDR  opcode, call qualifier, current PC
//           RET_ADDR           top entry (0 when empty)
//           EMPTY, FULL, COUNT occupancy status (registered)
//           OVF, UNF           sticky overflow / underflow flags
// Config  : RET_STACK_WRAP_EN  when defined, a push while full overwrites the
//           oldest entry (circular); otherwise the push is dropped.
module ret_stack
  import puc_pkg::*;
#(
  parameter int unsigned INSTR_ADDR_SIZE = 5,
  parameter int unsigned DEPTH           = 8,
  localparam int unsigned PTR_W          = $clog2(DEPTH),
  localparam int unsigned CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [1:0]                 OP_CODE,
  input  logic                       CALL,
  input  logic [INSTR_ADDR_SIZE-1:0] INSTR_ADDR,
  output logic [INSTR_ADDR_SIZE-1:0] RET_ADDR,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic [CNT_W-1:0]           COUNT,
  output logic                       OVF,
  output logic                       UNF
);

  // ptr_q is the next write slot; the top entry sits one below it (mod DEPTH).
  // When full, ptr_q also addresses the oldest entry, which is what lets the
  // circular mode overwrite it by a plain write at ptr_q.
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             we;
  logic [INSTR_ADDR_SIZE-1:0] rdata;

  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    case (OP_CODE)
      OP_RESTART: count_d = '0;
      OP_JMP: begin
        if (CALL) begin
          if (!full_q) begin
            we      = 1'b1;
            ptr_d   = ptr_inc;
            count_d = count_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
`ifdef RET_STACK_WRAP_EN
            we    = 1'b1;
            ptr_d = ptr_inc;
`endif
          end
        end
      end
      OP_RET: begin
        if (empty_q) begin
          unf_d = 1'b1;
        end else begin
          ptr_d   = ptr_dec;
          count_d = count_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q   <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  ret_stack_mem #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_ADDR_SIZE)
  ) u_mem (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .we_i    (we),
    .waddr_i (ptr_q),
    .wdata_i (INSTR_ADDR + INSTR_ADDR_SIZE'(1)),
    .raddr_i (ptr_dec),
    .rdata_o (rdata)
  );

  // Stale entries survive a restart, so the top must be masked when empty.
  assign RET_ADDR = empty_q ? '0 : rdata;
  assign EMPTY    = empty_q;
  assign FULL     = full_q;
  assign COUNT    = count_q;
  assign OVF      = ovf_q;
  assign UNF      = unf_q;

endmodule

// File: tb/tb_ret_stack.sv
// tb/tb_ret_stack.sv - directed self-checking bench for ret_stack (DEPTH=4, width 5)
module tb_ret_stack;
  import puc_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] OP_CODE;
  logic       CALL;
  logic [4:0] INSTR_ADDR;
  logic [4:0] RET_ADDR;
  logic       EMPTY, FULL, OVF, UNF;
  logic [2:0] COUNT;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ret_stack #(.INSTR_ADDR_SIZE(5), .DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .OP_CODE(OP_CODE), .CALL(CALL),
    .INSTR_ADDR(INSTR_ADDR), .RET_ADDR(RET_ADDR), .EMPTY(EMPTY),
    .FULL(FULL), .COUNT(COUNT), .OVF(OVF), .UNF(UNF)
  );

  // Apply one operation for one edge, then return 1 time unit after the edge
  // with the bus parked on a no-op.
  task automatic do_op(input logic [1:0] op, input logic c, input logic [4:0] a);
    OP_CODE = op; CALL = c; INSTR_ADDR = a;
    @(posedge CLK);
    #1;
    OP_CODE = OP_INC; CALL = 1'b0; INSTR_ADDR = 5'd0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    OP_CODE = OP_JMP; CALL = 1'b1; INSTR_ADDR = 5'd7;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (RET_ADDR !== 5'd0) begin errors++; $display("FAIL reset_ret_addr got=%0d exp=0", RET_ADDR); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", EMPTY); end
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", FULL); end
    checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", OVF); end
    checks++; if (UNF !== 1'b0) begin errors++; $display("FAIL reset_unf got=%b exp=0", UNF); end
    OP_CODE = OP_INC; CALL = 1'b0; INSTR_ADDR = 5'd0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_single_call();
    do_op(OP_JMP, 1'b1, 5'd5);
    checks++; if (RET_ADDR !== 5'd6) begin errors++; $display("FAIL call_ret_addr got=%0d exp=6", RET_ADDR); end
    checks++; if (COUNT !== 3'd1) begin errors++; $display("FAIL call_count got=%0d exp=1", COUNT); end
    checks++; if (EMPTY !== 1'b0) begin errors++; $display("FAIL call_empty got=%b exp=0", EMPTY); end
    do_op(OP_RET, 1'b0, 5'd6);
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL ret_empty got=%b exp=1", EMPTY); end
    checks++; if (RET_ADDR !== 5'd0) begin errors++; $display("FAIL ret_ret_addr got=%0d exp=0", RET_ADDR); end
    checks++; if (UNF !== 1'b0) begin errors++; $display("FAIL ret_unf got=%b exp=0", UNF); end
  endtask

  task automatic test_nesting();
    do_op(OP_JMP, 1'b1, 5'd3);
    do_op(OP_JMP, 1'b1, 5'd10);
    checks++; if (RET_ADDR !== 5'd11) begin errors++; $display("FAIL nest_second got=%0d exp=11", RET_ADDR); end
    do_op(OP_JMP, 1'b1, 5'd31);
    checks++; if (RET_ADDR !== 5'd0) begin errors++; $display("FAIL nest_wrap got=%0d exp=0", RET_ADDR); end
    checks++; if (COUNT !== 3'd3 || EMPTY !== 1'b0) begin errors++; $display("FAIL nest_count got=%0d/%b exp=3/0", COUNT, EMPTY); end
    do_op(OP_RET, 1'b0, 5'd0);
    checks++; if (RET_ADDR !== 5'd11) begin errors++; $display("FAIL nest_pop1 got=%0d exp=11", RET_ADDR); end
    do_op(OP_RET, 1'b0, 5'd11);
    checks++; if (RET_ADDR !== 5'd4) begin errors++; $display("FAIL nest_pop2 got=%0d exp=4", RET_ADDR); end
    do_op(OP_RET, 1'b0, 5'd4);
    checks++; if (EMPTY !== 1'b1 || COUNT !== 3'd0) begin errors++; $display("FAIL nest_pop3 got=%b/%0d exp=1/0", EMPTY, COUNT); end
  endtask

  task automatic test_overflow();
    logic [4:0] exp_pop [4];
`ifdef RET_STACK_WRAP_EN
    exp_pop[0] = 5'd6; exp_pop[1] = 5'd5; exp_pop[2] = 5'd4; exp_pop[3] = 5'd3;
`else
    exp_pop[0] = 5'd5; exp_pop[1] = 5'd4; exp_pop[2] = 5'd3; exp_pop[3] = 5'd2;
`endif
    for (int i = 1; i <= 3; i++) do_op(OP_JMP, 1'b1, 5'(i));
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL ovf_not_full got=%b exp=0", FULL); end
    do_op(OP_JMP, 1'b1, 5'd4);
    checks++; if (FULL !== 1'b1 || COUNT !== 3'd4) begin errors++; $display("FAIL ovf_full got=%b/%0d exp=1/4", FULL, COUNT); end
    checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", OVF); end
    do_op(OP_JMP, 1'b1, 5'd5);
    checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", OVF); end
    checks++; if (COUNT !== 3'd4 || FULL !== 1'b1) begin errors++; $display("FAIL ovf_count got=%0d/%b exp=4/1", COUNT, FULL); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (RET_ADDR !== exp_pop[i]) begin errors++; $display("FAIL ovf_pop%0d got=%0d exp=%0d", i, RET_ADDR, exp_pop[i]); end
      do_op(OP_RET, 1'b0, 5'd0);
    end
    checks++; if (EMPTY !== 1'b1 || OVF !== 1'b1) begin errors++; $display("FAIL ovf_drained got=%b/%b exp=1/1", EMPTY, OVF); end
  endtask

  task automatic test_nocall_jump();
    do_op(OP_JMP, 1'b1, 5'd20);
    do_op(OP_JMP, 1'b0, 5'd9);
    checks++; if (COUNT !== 3'd1 || RET_ADDR !== 5'd21) begin errors++; $display("FAIL jump_nocall got=%0d/%0d exp=1/21", COUNT, RET_ADDR); end
    do_op(OP_INC, 1'b1, 5'd12);
    checks++; if (COUNT !== 3'd1 || RET_ADDR !== 5'd21) begin errors++; $display("FAIL inc_nochange got=%0d/%0d exp=1/21", COUNT, RET_ADDR); end
    do_op(OP_RET, 1'b0, 5'd0);
  endtask

  task automatic test_underflow_restart();
    do_op(OP_RET, 1'b0, 5'd0);
    checks++; if (UNF !== 1'b1) begin errors++; $display("FAIL unf_set got=%b exp=1", UNF); end
    checks++; if (RET_ADDR !== 5'd0 || COUNT !== 3'd0) begin errors++; $display("FAIL unf_state got=%0d/%0d exp=0/0", RET_ADDR, COUNT); end
    do_op(OP_JMP, 1'b1, 5'd7);
    do_op(OP_JMP, 1'b1, 5'd8);
    checks++; if (COUNT !== 3'd2 || RET_ADDR !== 5'd9) begin errors++; $display("FAIL restart_pre got=%0d/%0d exp=2/9", COUNT, RET_ADDR); end
    do_op(OP_RESTART, 1'b0, 5'd0);
    checks++; if (EMPTY !== 1'b1 || COUNT !== 3'd0 || RET_ADDR !== 5'd0) begin errors++; $display("FAIL restart_empty got=%b/%0d/%0d exp=1/0/0", EMPTY, COUNT, RET_ADDR); end
    checks++; if (UNF !== 1'b1 || OVF !== 1'b1) begin errors++; $display("FAIL restart_sticky got=%b/%b exp=1/1", UNF, OVF); end
  endtask

  task automatic test_back_to_back();
    do_op(OP_JMP, 1'b1, 5'd1);
    checks++; if (RET_ADDR !== 5'd2 || COUNT !== 3'd1) begin errors++; $display("FAIL b2b_1 got=%0d/%0d exp=2/1", RET_ADDR, COUNT); end
    do_op(OP_JMP, 1'b1, 5'd2);
    checks++; if (RET_ADDR !== 5'd3 || COUNT !== 3'd2) begin errors++; $display("FAIL b2b_2 got=%0d/%0d exp=3/2", RET_ADDR, COUNT); end
    do_op(OP_RET, 1'b0, 5'd0);
    checks++; if (RET_ADDR !== 5'd2 || COUNT !== 3'd1) begin errors++; $display("FAIL b2b_3 got=%0d/%0d exp=2/1", RET_ADDR, COUNT); end
    do_op(OP_JMP, 1'b1, 5'd3);
    checks++; if (RET_ADDR !== 5'd4 || COUNT !== 3'd2) begin errors++; $display("FAIL b2b_4 got=%0d/%0d exp=4/2", RET_ADDR, COUNT); end
    do_op(OP_RET, 1'b0, 5'd0);
    checks++; if (RET_ADDR !== 5'd2) begin errors++; $display("FAIL b2b_5 got=%0d exp=2", RET_ADDR); end
    do_op(OP_RET, 1'b0, 5'd0);
    checks++; if (EMPTY !== 1'b1 || RET_ADDR !== 5'd0) begin errors++; $display("FAIL b2b_6 got=%b/%0d exp=1/0", EMPTY, RET_ADDR); end
  endtask

  task automatic test_async_reset();
    do_op(OP_JMP, 1'b1, 5'd14);
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (COUNT !== 3'd0 || EMPTY !== 1'b1 || RET_ADDR !== 5'd0) begin errors++; $display("FAIL areset_clear got=%0d/%b/%0d exp=0/1/0", COUNT, EMPTY, RET_ADDR); end
    checks++; if (OVF !== 1'b0 || UNF !== 1'b0) begin errors++; $display("FAIL areset_sticky got=%b/%b exp=0/0", OVF, UNF); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    OP_CODE = OP_INC; CALL = 1'b0; INSTR_ADDR = 5'd0; RST_N = 1'b0;
    test_reset();
    test_single_call();
    test_nesting();
    test_overflow();
    test_nocall_jump();
    test_underflow_restart();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
